uop_queue: RTL and testbench



---
 rtl/decode_pkg.sv | 30 +++
 rtl/uop_queue_mem.sv | 48 ++++
 rtl/uop_queue.sv | 123 ++++++++++++
 tb/tb_uop_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-side definitions for the micro-op queue.
//   UOP_W_DEF / BUNDLE_DEF : default uop width and maximum uops per bundle
//   cw_f  : width of the bundle "last index" field, max(1, clog2(bundle))
//   lw_f  : width of an occupancy count 0..depth, clog2(depth+1)
//   aw_f  : width of an entry address, max(1, clog2(depth))
//   uop_entry_t : one queue entry {first, last, uop} at the default width
package decode_pkg;

    localparam int UOP_W_DEF  = 16;
    localparam int BUNDLE_DEF = 3;

    function automatic int cw_f(input int bundle);
        return (bundle > 1) ? $clog2(bundle) : 1;
    endfunction

    function automatic int lw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int aw_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [UOP_W_DEF-1:0] uop;
    } uop_entry_t;

endpackage

// File: rtl/uop_queue_mem.sv
// Entry storage for uop_queue: DEPTH registers of {first, last, uop} with
// BUNDLE independent write ports and one asynchronous read port.
//   clk, a_rst : clock, asynchronous active-low reset (clears every entry)
//   wr_en      : per-port write enable
//   wr_addr    : per-port entry address, port k in [k*AW +: AW]
//   wr_data    : per-port entry, port k in [k*EW +: EW], layout {first,last,uop}
//   rd_addr    : read address
//   rd_data    : entry at rd_addr, combinational
module uop_queue_mem
    import decode_pkg::*;
#(
    parameter int UOP_W  = UOP_W_DEF,
    parameter int BUNDLE = BUNDLE_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic [BUNDLE-1:0]                 wr_en,
    input  logic [BUNDLE*aw_f(DEPTH)-1:0]     wr_addr,
    input  logic [BUNDLE*(UOP_W+2)-1:0]       wr_data,
    input  logic [aw_f(DEPTH)-1:0]            rd_addr,
    output logic [UOP_W+1:0]                  rd_data
);

    localparam int AW = aw_f(DEPTH);
    localparam int EW = UOP_W + 2;

    logic [EW-1:0] mem [DEPTH];

    // Entries are cleared on reset so an empty-queue read never returns X.
    // Active ports always target distinct entries, so port order is irrelevant.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int k = 0; k < BUNDLE; k++) begin
                if (wr_en[k]) begin
                    mem[wr_addr[k*AW +: AW]] <= wr_data[k*EW +: EW];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uop_queue.sv
// Micro-op buffer between decode and the execute issue port. Accepts a whole
// bundle of 1..BUNDLE uops per cycle and issues them in order, one per cycle.
//   clk, a_rst   : clock, asynchronous active-low reset
//   flush        : synchronous discard of all queued uops (beats push/pop)
//   hold         : freezes all state, forces in_ready and out_valid low
//   in_valid/in_ready : bundle handshake; in_ready needs room for BUNDLE uops
//   in_uops      : uop k in [k*UOP_W +: UOP_W], uop 0 issues first
//   in_last_idx  : uop count minus one, clamped to BUNDLE-1
//   out_valid/out_ready : per-uop issue handshake
//   out_uop, out_first, out_last : head entry and its bundle-boundary tags
//   level, empty, full : occupancy
module uop_queue
    import decode_pkg::*;
#(
    parameter int UOP_W  = UOP_W_DEF,
    parameter int BUNDLE = BUNDLE_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       a_rst,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BUNDLE*UOP_W-1:0]    in_uops,
    input  logic [cw_f(BUNDLE)-1:0]    in_last_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UOP_W-1:0]           out_uop,
    output logic                       out_first,
    output logic                       out_last,
    output logic [lw_f(DEPTH)-1:0]     level,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = cw_f(BUNDLE);
    localparam int LW = lw_f(DEPTH);
    localparam int AW = aw_f(DEPTH);
    localparam int EW = UOP_W + 2;

    // Out-of-range last index saturates to a full bundle.
    function automatic logic [LW-1:0] clamp_count(input logic [CW-1:0] last_idx);
        if (int'(last_idx) > BUNDLE - 1) begin
            return LW'(BUNDLE);
        end
        return LW'(last_idx) + LW'(1);
    endfunction

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        n_in;
    logic                 push;
    logic                 pop;
    logic [BUNDLE-1:0]    wr_en;
    logic [BUNDLE*AW-1:0] wr_addr;
    logic [BUNDLE*EW-1:0] wr_data;
    logic [EW-1:0]        rd_data;

    assign n_in = clamp_count(in_last_idx);

    // Room for a worst-case bundle; deliberately ignores in_last_idx so that
    // in_ready never depends on in_valid-side data.
    assign in_ready  = ~hold & ~flush & ((LW'(DEPTH) - level) >= LW'(BUNDLE));
    assign push      = in_valid & in_ready;
    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign out_valid = ~hold & ~empty;
    assign pop       = out_valid & out_ready;

    // Bundle slot k lands at wr_ptr+k; address wrap is free since DEPTH is 2^AW.
    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < BUNDLE; k++) begin
            wr_en[k]              = push && (LW'(k) < n_in);
            wr_addr[k*AW +: AW]   = wr_ptr + AW'(k);
            wr_data[k*EW +: EW]   = {(k == 0), (LW'(k) == n_in - LW'(1)),
                                     in_uops[k*UOP_W +: UOP_W]};
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // hold needs no branch here: it already forces push and pop low.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(n_in);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (push ? n_in : LW'(0)) - (pop ? LW'(1) : LW'(0));
        end
    end

    uop_queue_mem #(
        .UOP_W  (UOP_W),
        .BUNDLE (BUNDLE),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .a_rst   (a_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign out_uop   = rd_data[UOP_W-1:0];
    assign out_last  = rd_data[UOP_W];
    assign out_first = rd_data[UOP_W+1];

endmodule

// File: tb/tb_uop_queue.sv
// Bench for uop_queue (UOP_W=16, BUNDLE=3, DEPTH=8): directed scenarios and
// random traffic, compared every cycle against a queue-of-entries model.
module tb_uop_queue;

    localparam int UOP_W  = 16;
    localparam int BUNDLE = 3;
    localparam int DEPTH  = 8;

    logic        clk;
    logic        a_rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_uops;
    logic [1:0]  in_last_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_uop;
    logic        out_first;
    logic        out_last;
    logic [3:0]  level;
    logic        empty;
    logic        full;

    uop_queue #(
        .UOP_W  (UOP_W),
        .BUNDLE (BUNDLE),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .flush       (flush),
        .hold        (hold),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_uops     (in_uops),
        .in_last_idx (in_last_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_uop     (out_uop),
        .out_first   (out_first),
        .out_last    (out_last),
        .level       (level),
        .empty       (empty),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] uop;
        logic        first;
        logic        last;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        logic exp_ov;
        exp_rdy = !hold && !flush && (DEPTH - mq.size() >= BUNDLE);
        exp_ov  = !hold && (mq.size() != 0);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("level", 32'(level), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        if (exp_ov) begin
            check("out_uop", 32'(out_uop), 32'(mq[0].uop));
            check("out_first", 32'(out_first), 32'(mq[0].first));
            check("out_last", 32'(out_last), 32'(mq[0].last));
        end
    endtask

    // Called at a falling edge: drive, check, clock, update model.
    task automatic step(input logic v, input logic [1:0] idx, input logic [47:0] u,
                        input logic ordy, input logic hld, input logic fl);
        int   n;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        in_valid    = v;
        in_last_idx = idx;
        in_uops     = u;
        out_ready   = ordy;
        hold        = hld;
        flush       = fl;
        #1;
        check_outputs();
        do_push = v && !hld && !fl && (DEPTH - mq.size() >= BUNDLE);
        do_pop  = ordy && !hld && (mq.size() != 0);
        n       = (idx > 2) ? 3 : int'(idx) + 1;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) e = mq.pop_front();
            if (do_push) begin
                for (int k = 0; k < n; k++) begin
                    e.uop   = u[k*16 +: 16];
                    e.first = (k == 0);
                    e.last  = (k == n - 1);
                    mq.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
            step(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 1'b0);
        end
        check("drained", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        a_rst = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        in_uops = '0; in_last_idx = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        check("rst_first", 32'(out_first), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        @(negedge clk);
        a_rst = 1'b1;

        // Three-uop bundle issues over the following three cycles.
        step(1'b1, 2'd2, {16'hA003, 16'hA002, 16'hA001}, 1'b1, 1'b0, 1'b0);
        #1;
        check("t1_level", 32'(level), 32'd3);
        check("t1_head", 32'(out_uop), 32'hA001);
        check("t1_first", 32'(out_first), 32'd1);
        drain();

        // Single-uop bundles with no consumer: in_ready drops at level 6.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd0, {32'h0, 16'(16'hC000 + i)}, 1'b0, 1'b0, 1'b0);
        end
        #1;
        check("rdy_at_6", 32'(in_ready), 32'd0);
        step(1'b1, 2'd0, 48'h0000_0000_CFFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("rdy_at_5", 32'(in_ready), 32'd1);
        drain();

        // Wrap-around: flush to zero pointers, advance them to 6, push 3.
        step(1'b0, 2'd0, 48'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd0, 48'h0000_0000_D000, 1'b1, 1'b0, 1'b0);
        end
        drain();
        step(1'b1, 2'd2, {16'hB003, 16'hB002, 16'hB001}, 1'b0, 1'b0, 1'b0);
        #1;
        check("wrap_level", 32'(level), 32'd3);
        drain();

        // Simultaneous push of 2 and pop at level 4.
        step(1'b1, 2'd1, 48'h0000_E002_E001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 48'h0000_E004_E003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 48'h0000_E006_E005, 1'b1, 1'b0, 1'b0);
        #1;
        check("pushpop_level", 32'(level), 32'd5);

        // Flush beats push and pop.
        step(1'b1, 2'd2, 48'hF003_F002_F001, 1'b1, 1'b0, 1'b1);
        #1;
        check("flush_level", 32'(level), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_ovalid", 32'(out_valid), 32'd0);

        // Hold for four cycles at level 3, then a clamped bundle.
        step(1'b1, 2'd2, 48'h1003_1002_1001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 48'h0000_0000_2222, 1'b1, 1'b1, 1'b0);
        end
        #1;
        check("hold_level", 32'(level), 32'd3);
        step(1'b1, 2'd3, 48'h3003_3002_3001, 1'b0, 1'b0, 1'b0);
        #1;
        check("clamp_level", 32'(level), 32'd6);
        drain();

        // Asynchronous reset mid-operation.
        step(1'b1, 2'd2, 48'h4003_4002_4001, 1'b0, 1'b0, 1'b0);
        #2;
        a_rst = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_ovalid", 32'(out_valid), 32'd0);
        mq.delete();
        @(negedge clk);
        a_rst = 1'b1;
        step(1'b1, 2'd1, 48'h0000_5002_5001, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 31) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
